adc_capture_streamer: RTL and testbench

Parametrised successor to the single-channel ADC capture and UART streaming control path. It is command-driven from UART RX bytes and runs an ADC reset, calibration and sampling sequence across NUM_CH sub-ADC channels. Captured frames are buffered in an internal FIFO and serialised as bytes to the UART TX. It sits between the uart_rx/uart_tx pair and the chip-side ADC control pins, replacing the fixed FSM.

---
 rtl/adc_capture_streamer_if.sv | 27 ++
 rtl/adc_capture_streamer.sv | 198 +++++++++++++++++++
 tb/tb_adc_capture_streamer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_streamer_if.sv
// UART byte link and ADC control/data pins seen by adc_capture_streamer.
// The master modport is the streamer side and the slave modport is the pad/UART side.
interface adc_capture_streamer_if #(
  parameter int unsigned NUM_bit = 6,
  parameter int unsigned NUM_CH  = 2
);
  logic [7:0]                uart_rdata;
  logic                      uart_vld;
  logic [7:0]                uart_wdata;
  logic                      uart_wreq;
  logic                      uart_rdy;
  logic                      adc_ack;
  logic [NUM_CH*NUM_bit-1:0] adc_dout;
  logic                      adc_rstn;
  logic                      adc_calib_ena;
  logic                      adc_ena;

  modport master (
    input  uart_rdata, uart_vld, uart_rdy, adc_ack, adc_dout,
    output uart_wdata, uart_wreq, adc_rstn, adc_calib_ena, adc_ena
  );

  modport slave (
    output uart_rdata, uart_vld, uart_rdy, adc_ack, adc_dout,
    input  uart_wdata, uart_wreq, adc_rstn, adc_calib_ena, adc_ena
  );
endinterface

// File: rtl/adc_capture_streamer.sv
// Command-driven ADC reset/calibrate/sample sequencer with a frame FIFO that streams
// captured frames to the UART transmitter one channel byte at a time.
module adc_capture_streamer #(
  parameter int unsigned NUM_bit         = 6,
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned NUM_Sampled     = 102400,
  parameter int unsigned NUM_Calibration = 1000,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned RST_CYCLES      = 16,
  parameter logic [7:0]  CMD_START       = 8'h53,
  parameter logic [7:0]  CMD_CALIB       = 8'h43,
  parameter logic [7:0]  CMD_ABORT       = 8'h58
) (
  input  logic                             clk,
  input  logic                             rst,
  adc_capture_streamer_if.master           bus,
  output logic [2:0]                       state,
  output logic [$clog2(NUM_Sampled+1)-1:0] cnt_sampled,
  output logic                             overflow
);
  localparam int unsigned DW = NUM_CH * NUM_bit;
  localparam int unsigned CW = $clog2(NUM_Sampled + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned RW = $clog2(NUM_CH + 1);
  localparam int unsigned TW = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StArst   = 3'd1,
    StCalib  = 3'd2,
    StSample = 3'd3,
    StDrain  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          mode_calib_q, mode_calib_d;
  logic [TW-1:0] arst_cnt_q, arst_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          overflow_q, overflow_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [DW-1:0] frame_q, frame_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          hold_q, hold_d, seen_low_q, seen_low_d;
  logic [1:0]    hi_cnt_q, hi_cnt_d;

  logic       cmd_start, cmd_calib, abort;
  logic       fifo_empty, fifo_full, push, pop;
  logic       ser_busy, guard_ok, send, arst_done;
  logic [7:0] cur_byte;

  assign cmd_start  = bus.uart_vld && (bus.uart_rdata == CMD_START);
  assign cmd_calib  = bus.uart_vld && (bus.uart_rdata == CMD_CALIB);
  assign abort      = bus.uart_vld && (bus.uart_rdata == CMD_ABORT) && (state_q != StIdle);
  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign arst_done  = (arst_cnt_q == TW'(RST_CYCLES - 1));
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = (state_q == StSample) && bus.adc_ack && !fifo_full && !abort;
  assign ser_busy   = (rem_q != '0);
  // Frames stay queued while the transmitter is busy so a stalled UART backs up the FIFO.
  assign pop        = !ser_busy && !fifo_empty && bus.uart_rdy && !abort;
  assign guard_ok   = !hold_q || (bus.uart_rdy && (seen_low_q || (hi_cnt_q == 2'd2)));
  assign send       = ser_busy && bus.uart_rdy && guard_ok && !abort;

  always_comb begin
    cur_byte = '0;
    cur_byte[NUM_bit-1:0] = frame_q[NUM_bit-1:0];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (cmd_start || cmd_calib) state_d = StArst;
      StArst:   if (arst_done) state_d = mode_calib_q ? StCalib : StSample;
      StCalib:  if (bus.adc_ack && (cnt_inc == CW'(NUM_Calibration))) state_d = StIdle;
      StSample: if (bus.adc_ack && (cnt_inc == CW'(NUM_Sampled))) state_d = StDrain;
      StDrain:  if (fifo_empty && !ser_busy) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  // Outputs
  always_comb begin
    state             = state_q;
    bus.adc_rstn      = (state_q != StArst);
    bus.adc_calib_ena = (state_q == StCalib);
    bus.adc_ena       = (state_q == StSample);
    bus.uart_wreq     = send;
    bus.uart_wdata    = send ? cur_byte : 8'h00;
    cnt_sampled       = cnt_q;
    overflow          = overflow_q;
  end

  // Counters, FIFO pointers, serialiser and transmit spacing guard
  always_comb begin
    mode_calib_d = mode_calib_q;
    arst_cnt_d   = arst_cnt_q;
    cnt_d        = cnt_q;
    overflow_d   = overflow_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    frame_d      = frame_q;
    rem_d        = rem_q;
    hold_d       = hold_q;
    seen_low_d   = seen_low_q;
    hi_cnt_d     = hi_cnt_q;

    if (state_q == StIdle) begin
      arst_cnt_d = '0;
      if (cmd_calib) begin
        mode_calib_d = 1'b1;
        cnt_d        = '0;
      end else if (cmd_start) begin
        mode_calib_d = 1'b0;
        cnt_d        = '0;
        overflow_d   = 1'b0;
      end
    end
    if ((state_q == StArst) && !arst_done) arst_cnt_d = arst_cnt_q + 1'b1;
    if ((state_q == StCalib) && bus.adc_ack) begin
      cnt_d = (cnt_inc == CW'(NUM_Calibration)) ? '0 : cnt_inc;
    end
    if ((state_q == StSample) && bus.adc_ack) begin
      cnt_d = cnt_inc;
      if (fifo_full) overflow_d = 1'b1;
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      frame_d  = mem_q[rd_ptr_q[AW-1:0]];
      rem_d    = RW'(NUM_CH);
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (send) begin
      frame_d = frame_q >> NUM_bit;
      rem_d   = rem_q - 1'b1;
    end

    // The guard survives an abort so a byte already handed over is not stepped on.
    if (send) begin
      hold_d     = 1'b1;
      seen_low_d = 1'b0;
      hi_cnt_d   = '0;
    end else if (hold_q) begin
      if (bus.uart_rdy && (seen_low_q || (hi_cnt_q == 2'd2))) hold_d = 1'b0;
      else if (!bus.uart_rdy) seen_low_d = 1'b1;
      else hi_cnt_d = hi_cnt_q + 1'b1;
    end

    if (abort) begin
      cnt_d      = cnt_q;
      overflow_d = overflow_q;
      rd_ptr_d   = wr_ptr_q;
      rem_d      = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_calib_q <= 1'b0;
      arst_cnt_q   <= '0;
      cnt_q        <= '0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      frame_q      <= '0;
      rem_q        <= '0;
      hold_q       <= 1'b0;
      seen_low_q   <= 1'b0;
      hi_cnt_q     <= '0;
    end else begin
      mode_calib_q <= mode_calib_d;
      arst_cnt_q   <= arst_cnt_d;
      cnt_q        <= cnt_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      frame_q      <= frame_d;
      rem_q        <= rem_d;
      hold_q       <= hold_d;
      seen_low_q   <= seen_low_d;
      hi_cnt_q     <= hi_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.adc_dout;
  end
endmodule

// File: tb/tb_adc_capture_streamer.sv
// Directed bench: instance a uses a 16-deep FIFO with short runs, instance b a 2-deep FIFO
// to force frame drops.
module tb_adc_capture_streamer;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  adc_capture_streamer_if #(.NUM_bit(6), .NUM_CH(2)) if_a ();
  adc_capture_streamer_if #(.NUM_bit(6), .NUM_CH(2)) if_b ();

  logic [2:0] state_a, state_b;
  logic [2:0] cnt_a, cnt_b;
  logic       ovf_a, ovf_b;

  adc_capture_streamer #(
    .NUM_bit(6), .NUM_CH(2), .NUM_Sampled(4), .NUM_Calibration(3),
    .FIFO_DEPTH(16), .RST_CYCLES(16)
  ) u_a (
    .clk(clk), .rst(rst_a), .bus(if_a), .state(state_a), .cnt_sampled(cnt_a), .overflow(ovf_a)
  );

  adc_capture_streamer #(
    .NUM_bit(6), .NUM_CH(2), .NUM_Sampled(5), .NUM_Calibration(3),
    .FIFO_DEPTH(2), .RST_CYCLES(16)
  ) u_b (
    .clk(clk), .rst(rst_b), .bus(if_b), .state(state_b), .cnt_sampled(cnt_b), .overflow(ovf_b)
  );

  logic [7:0] tx_a[$];
  logic [7:0] tx_b[$];

  always @(negedge clk) begin
    if (if_a.uart_wreq === 1'b1) tx_a.push_back(if_a.uart_wdata);
    if (if_b.uart_wreq === 1'b1) tx_b.push_back(if_b.uart_wdata);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cmd(input int sel, input logic [7:0] b);
    if (sel == 0) begin
      if_a.uart_vld = 1'b1; if_a.uart_rdata = b; tick(); if_a.uart_vld = 1'b0;
    end else begin
      if_b.uart_vld = 1'b1; if_b.uart_rdata = b; tick(); if_b.uart_vld = 1'b0;
    end
  endtask

  task automatic ack(input int sel, input logic [11:0] d);
    if (sel == 0) begin
      if_a.adc_ack = 1'b1; if_a.adc_dout = d; tick(); if_a.adc_ack = 1'b0;
    end else begin
      if_b.adc_ack = 1'b1; if_b.adc_dout = d; tick(); if_b.adc_ack = 1'b0;
    end
  endtask

  task automatic wait_rstn(input int sel, output int n);
    n = 0;
    while (((sel == 0) ? if_a.adc_rstn : if_b.adc_rstn) === 1'b0 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_idle(input int sel, output int n);
    n = 0;
    while (((sel == 0) ? state_a : state_b) !== 3'd0 && n < 500) begin
      n++;
      tick();
    end
  endtask

  logic [11:0] run1_in  [4] = '{12'hFC1, 12'h041, 12'h000, 12'hFFF};
  logic [7:0]  run1_exp [8] = '{8'h01, 8'h3F, 8'h01, 8'h01, 8'h00, 8'h00, 8'h3F, 8'h3F};
  logic [11:0] run2_in  [4] = '{12'h5A3, 12'h7C0, 12'h83F, 12'h2A5};
  logic [7:0]  run2_exp [8] = '{8'h23, 8'h16, 8'h00, 8'h1F, 8'h3F, 8'h20, 8'h25, 8'h0A};
  logic [7:0]  ovf_exp  [4] = '{8'h01, 8'h00, 8'h02, 8'h00};

  initial begin
    int n;
    rst_a = 1'b1; rst_b = 1'b1;
    if_a.uart_rdata = '0; if_a.uart_vld = 1'b0; if_a.uart_rdy = 1'b1;
    if_a.adc_ack = 1'b0; if_a.adc_dout = '0;
    if_b.uart_rdata = '0; if_b.uart_vld = 1'b0; if_b.uart_rdy = 1'b0;
    if_b.adc_ack = 1'b0; if_b.adc_dout = '0;
    tick(3);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    chk("rst_state", state_a, 0);
    chk("rst_adc_rstn", if_a.adc_rstn, 1);
    chk("rst_calib_ena", if_a.adc_calib_ena, 0);
    chk("rst_adc_ena", if_a.adc_ena, 0);
    chk("rst_wreq", if_a.uart_wreq, 0);
    chk("rst_wdata", if_a.uart_wdata, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_overflow", ovf_a, 0);

    // Normal sampling run, transmitter always ready
    cmd(0, 8'h41);
    chk("ignore_byte_state", state_a, 0);
    tx_a.delete();
    cmd(0, 8'h53);
    chk("start_to_arst", state_a, 1);
    wait_rstn(0, n);
    chk("arst_len_sample", n, 16);
    chk("sample_state", state_a, 3);
    chk("sample_adc_ena", if_a.adc_ena, 1);
    for (int i = 0; i < 4; i++) ack(0, run1_in[i]);
    chk("drain_state", state_a, 4);
    chk("drain_adc_ena", if_a.adc_ena, 0);
    chk("run1_cnt", cnt_a, 4);
    wait_idle(0, n);
    chk("run1_idle", state_a, 0);
    chk("run1_tx_count", tx_a.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("run1_byte%0d", i), tx_a[i], run1_exp[i]);
    chk("run1_cnt_hold", cnt_a, 4);
    chk("run1_overflow", ovf_a, 0);

    // Calibration, with a start command that must be ignored mid-run
    tick(5);
    tx_a.delete();
    cmd(0, 8'h43);
    chk("calib_to_arst", state_a, 1);
    wait_rstn(0, n);
    chk("arst_len_calib", n, 16);
    chk("calib_state", state_a, 2);
    chk("calib_ena_hi", if_a.adc_calib_ena, 1);
    chk("calib_adc_ena", if_a.adc_ena, 0);
    ack(0, 12'h123);
    tick();
    cmd(0, 8'h53);
    chk("calib_start_ignored", state_a, 2);
    ack(0, 12'h456);
    chk("calib_after_2", state_a, 2);
    ack(0, 12'h789);
    chk("calib_done_state", state_a, 0);
    chk("calib_done_ena", if_a.adc_calib_ena, 0);
    chk("calib_done_cnt", cnt_a, 0);
    tick(10);
    chk("calib_no_tx", tx_a.size(), 0);

    // Abort mid-sample with frames queued behind a stalled transmitter
    if_a.uart_rdy = 1'b0;
    cmd(0, 8'h53);
    wait_rstn(0, n);
    ack(0, 12'hFC1);
    ack(0, 12'h041);
    cmd(0, 8'h58);
    chk("abort_state", state_a, 0);
    chk("abort_adc_ena", if_a.adc_ena, 0);
    chk("abort_adc_rstn", if_a.adc_rstn, 1);
    if_a.uart_rdy = 1'b1;
    tick(20);
    chk("abort_no_tx", tx_a.size(), 0);
    chk("abort_still_idle", state_a, 0);
    chk("abort_overflow", ovf_a, 0);

    // Asynchronous reset mid-sample, then a clean run
    cmd(0, 8'h53);
    wait_rstn(0, n);
    ack(0, 12'hABC);
    ack(0, 12'hDEF);
    #2;
    rst_a = 1'b1;
    #1;
    chk("mid_rst_state", state_a, 0);
    chk("mid_rst_adc_ena", if_a.adc_ena, 0);
    chk("mid_rst_adc_rstn", if_a.adc_rstn, 1);
    chk("mid_rst_cnt", cnt_a, 0);
    chk("mid_rst_wreq", if_a.uart_wreq, 0);
    chk("mid_rst_wdata", if_a.uart_wdata, 0);
    tick(2);
    rst_a = 1'b0;
    tick();
    tx_a.delete();
    cmd(0, 8'h53);
    wait_rstn(0, n);
    chk("run2_arst_len", n, 16);
    for (int i = 0; i < 4; i++) ack(0, run2_in[i]);
    wait_idle(0, n);
    chk("run2_idle", state_a, 0);
    chk("run2_tx_count", tx_a.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("run2_byte%0d", i), tx_a[i], run2_exp[i]);
    chk("run2_cnt", cnt_a, 4);

    // Overflow on the 2-deep instance: transmitter stalled during five back-to-back acks
    tx_b.delete();
    cmd(1, 8'h53);
    wait_rstn(1, n);
    chk("b_sample_state", state_b, 3);
    for (int i = 1; i <= 5; i++) ack(1, 12'(i));
    chk("b_drain_state", state_b, 4);
    chk("b_cnt", cnt_b, 5);
    chk("b_overflow", ovf_b, 1);
    tick(5);
    chk("b_stall_drain", state_b, 4);
    chk("b_stall_no_tx", tx_b.size(), 0);
    if_b.uart_rdy = 1'b1;
    wait_idle(1, n);
    chk("b_idle", state_b, 0);
    chk("b_tx_count", tx_b.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("b_byte%0d", i), tx_b[i], ovf_exp[i]);
    chk("b_overflow_sticky", ovf_b, 1);
    cmd(1, 8'h53);
    chk("b_restart_arst", state_b, 1);
    chk("b_restart_ovf_clr", ovf_b, 0);
    chk("b_restart_cnt_clr", cnt_b, 0);
    cmd(1, 8'h58);
    chk("b_abort_arst_state", state_b, 0);
    chk("b_abort_arst_rstn", if_b.adc_rstn, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
